// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
//   in_valid/in_data : source offers a stream byte
//   in_ready         : loader accepts a byte this cycle
//   imem_we          : one-cycle write strobe
//   imem_addr        : word-aligned byte address of the write
//   imem_wdata       : assembled big-endian instruction word
// master = stream source / memory observer, slave = loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader for the single-cycle core.
// Accepts a framed byte stream (N_hi, N_lo, N*4 data bytes MSB first, XOR
// checksum byte), writes each assembled word to consecutive word addresses
// starting at BASE_ADDR and releases the core only after a good checksum.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   bus      : stream handshake + instruction-memory write (slave side)
//   core_run : core may leave reset (mirrors done)
//   done     : load finished with good checksum (sticky)
//   error    : load aborted (sticky)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          core_run,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] n_full;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [23:0] word_sh;
  logic [7:0]  xor_acc;
  logic        accept;

  assign accept   = bus.in_valid && bus.in_ready;
  assign n_full   = {n_hi, bus.in_data};
  assign core_run = done;

  always_comb begin
    state_nx = state;
    case (state)
      HDR_HI: if (accept) state_nx = HDR_LO;
      HDR_LO: if (accept) begin
        if (32'(n_full) > MAX_WORDS) state_nx = ERR;
        else if (n_full == '0)       state_nx = CHK;
        else                         state_nx = DATA;
      end
      DATA: if (accept && byte_cnt == 2'd3 && (word_idx + 16'd1) == n_words)
        state_nx = CHK;
      CHK: if (accept) state_nx = (bus.in_data == xor_acc) ? DONE : ERR;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= HDR_HI;
      n_hi           <= '0;
      n_words        <= '0;
      byte_cnt       <= '0;
      word_idx       <= '0;
      word_sh        <= '0;
      xor_acc        <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state        <= state_nx;
      // Registered ready and status flags are derived from the next state so
      // they change on the same edge the FSM enters a terminal state.
      bus.in_ready <= !(state_nx == DONE || state_nx == ERR);
      done         <= (state_nx == DONE);
      error        <= (state_nx == ERR);
      bus.imem_we  <= 1'b0;

      if (accept && state != CHK) xor_acc <= xor_acc ^ bus.in_data;

      if (accept) begin
        case (state)
          HDR_HI: n_hi <= bus.in_data;
          HDR_LO: n_words <= n_full;
          DATA: begin
            word_sh  <= {word_sh[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              bus.imem_wdata <= {word_sh, bus.in_data};
              word_idx       <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
